// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60 VGA raster.
//   - DEF_* : default visible/porch/sync sizes and the pixel/move dividers
//   - H_TOT, V_TOT, HS_*, VS_* : derived totals and sync windows at defaults
//   - CNT_W : width of the raster counters
// No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W        = 10;

    localparam int DEF_PIX_DIV  = 4;
    localparam int DEF_MOVE_DIV = 1;

    localparam int DEF_H_VIS    = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_VIS    = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOT    = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOT    = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync windows are half-open: [START, END)
    localparam int HS_START = DEF_H_VIS + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VIS + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
// Bundle of raster timing signals produced by vga_sync_gen and consumed by
// the drawing objects (paddles, ball, occupancy logic) and the VGA pins.
//   pixpulse  : one-clk pixel enable
//   hcount    : current pixel column
//   vcount    : current line
//   hsync     : horizontal sync, active low
//   vsync     : vertical sync, active low
//   blank     : high outside the visible area
//   frame_end : high during the last pixel of a frame
//   move_tick : high during the last pixel of every MOVE_DIV-th frame
// Modports: master (timing generator), slave (consumers).
// ---------------------------------------------------------------------------
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic             pixpulse;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic             frame_end;
    logic             move_tick;

    modport master (
        output pixpulse, hcount, vcount, hsync, vsync, blank, frame_end, move_tick
    );

    modport slave (
        input  pixpulse, hcount, vcount, hsync, vsync, blank, frame_end, move_tick
    );

endinterface

// File: rtl/pix_enable_div.sv
// ---------------------------------------------------------------------------
// pix_enable_div
// Clock-enable divider: counts 0..DIV-1 every clk and raises pixpulse for
// the single clock in which the count sits at DIV-1.
//   clk      : system clock
//   rst      : asynchronous active-high reset (count cleared to 0)
//   pixpulse : one-clk enable, high 1 of every DIV clocks
// ---------------------------------------------------------------------------
module pix_enable_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixpulse
);

    localparam int           DW   = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // Decoding from the register keeps pixpulse low in reset and places the
    // first pulse in the DIV-th clock after release.
    assign pixpulse = (div_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// Pixel-timing master for the VGA path. Divides clk into a pixel enable,
// walks the raster (hcount, vcount), and produces registered sync, blank,
// end-of-frame and frame-rate move strobes.
//   clk : system clock (100 MHz)
//   rst : asynchronous active-high reset
//   vga : vga_sync_gen_if.master carrying pixpulse, hcount, vcount, hsync,
//         vsync, blank, frame_end, move_tick
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int MOVE_DIV = DEF_MOVE_DIV
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int H_LEN = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_LEN = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_LEN - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_LEN - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_VIS + V_FP + V_SYNC);

    localparam int               FC_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(MOVE_DIV - 1);

    // Raster totals must fit the counters; dividers must be meaningful.
    if (H_LEN > (1 << CNT_W) || V_LEN > (1 << CNT_W)) begin : g_size_check
        $error("vga_sync_gen: H_TOT/V_TOT exceed counter range");
    end
    if (PIX_DIV < 2 || MOVE_DIV < 1) begin : g_div_check
        $error("vga_sync_gen: PIX_DIV must be >=2 and MOVE_DIV >=1");
    end

    logic             pixpulse;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic             frame_end;
    logic             move_tick;
    logic [FC_W-1:0]  frame_cnt;

    logic             at_line_end;
    logic             at_frame_end;
    logic [CNT_W-1:0] next_h;
    logic [CNT_W-1:0] next_v;
    logic             next_last;

    pix_enable_div #(
        .DIV(PIX_DIV)
    ) u_pix_div (
        .clk     (clk),
        .rst     (rst),
        .pixpulse(pixpulse)
    );

    // Raster position that becomes current on the next pixpulse edge.
    always_comb begin
        at_line_end  = (hcount == H_LAST);
        at_frame_end = at_line_end && (vcount == V_LAST);
        next_h       = at_line_end ? '0 : hcount + CNT_W'(1);
        next_v       = vcount;
        if (at_frame_end) begin
            next_v = '0;
        end else if (at_line_end) begin
            next_v = vcount + CNT_W'(1);
        end
        next_last    = (next_h == H_LAST) && (next_v == V_LAST);
    end

    // Sync, blank and strobes are decoded from the next position and loaded
    // with it, so they always match the counters being presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank     <= 1'b0;
            frame_end <= 1'b0;
            move_tick <= 1'b0;
            frame_cnt <= '0;
        end else if (pixpulse) begin
            hcount    <= next_h;
            vcount    <= next_v;
            hsync     <= !((next_h >= HS_LO) && (next_h < HS_HI));
            vsync     <= !((next_v >= VS_LO) && (next_v < VS_HI));
            blank     <= (next_h >= H_VIS_C) || (next_v >= V_VIS_C);
            frame_end <= next_last;
            move_tick <= next_last && (frame_cnt == FC_LAST);
            if (at_frame_end) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
            end
        end
    end

    assign vga.pixpulse  = pixpulse;
    assign vga.hcount    = hcount;
    assign vga.vcount    = vcount;
    assign vga.hsync     = hsync;
    assign vga.vsync     = vsync;
    assign vga.blank     = blank;
    assign vga.frame_end = frame_end;
    assign vga.move_tick = move_tick;

endmodule
